// File: rtl/alu_mult_ctrl_if.sv
// Bundle between the EX stage, the shared Alu and the multiply sequencer.
// The sequencer takes the slave side; the pipeline/ALU environment takes the master side.
interface alu_mult_ctrl_if;
    logic        start;
    logic        signed_op;
    logic        cancel;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] alu_out;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic        alu_unsig;
    logic        alu_sel;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, signed_op, cancel, rs_val, rt_val, alu_out,
        input  alu_a, alu_b, alu_op, alu_unsig, alu_sel, busy, done, hi, lo
    );

    modport slave (
        input  start, signed_op, cancel, rs_val, rt_val, alu_out,
        output alu_a, alu_b, alu_op, alu_unsig, alu_sel, busy, done, hi, lo
    );
endinterface

// File: rtl/alu_mult_ctrl.sv
// MULT/MULTU sequencer: borrows the shared 32-bit Alu for a 32-cycle shift-and-add
// multiply, with sign handling done by ALU negations so no private adder exists.
module alu_mult_ctrl (
    input logic           clock,
    input logic           reset_n,
    alu_mult_ctrl_if.slave bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_NEG_A   = 3'd1;
    localparam logic [2:0] S_NEG_B   = 3'd2;
    localparam logic [2:0] S_ITER    = 3'd3;
    localparam logic [2:0] S_FIX_LO  = 3'd4;
    localparam logic [2:0] S_FIX_HI1 = 3'd5;
    localparam logic [2:0] S_FIX_HI2 = 3'd6;
    localparam logic [2:0] S_DONE    = 3'd7;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b110;

    logic [2:0]  state_q,  state_d;
    logic [31:0] mcand_q,  mcand_d;
    logic [31:0] acc_hi_q, acc_hi_d;
    logic [31:0] acc_lo_q, acc_lo_d;
    logic        neg_res_q, neg_res_d;
    logic [4:0]  cnt_q,    cnt_d;
    logic [31:0] hi_q,     hi_d;
    logic [31:0] lo_q,     lo_d;

    logic        carry;

    // ALU operand steering; the ALU result comes back on alu_out in the same cycle.
    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        bus.alu_sel = 1'b0;
        bus.alu_a   = '0;
        bus.alu_b   = '0;
        bus.alu_op  = OP_AND;
        unique case (state_q)
            S_NEG_A: begin
                bus.alu_sel = 1'b1;
                bus.alu_op  = OP_SUB;
                bus.alu_b   = mcand_q;
            end
            S_NEG_B: begin
                bus.alu_sel = 1'b1;
                bus.alu_op  = OP_SUB;
                bus.alu_b   = acc_lo_q;
            end
            S_ITER: begin
                bus.alu_sel = 1'b1;
                bus.alu_op  = OP_ADD;
                bus.alu_a   = acc_hi_q;
                bus.alu_b   = acc_lo_q[0] ? mcand_q : '0;
            end
            S_FIX_LO: begin
                bus.alu_sel = 1'b1;
                bus.alu_op  = OP_SUB;
                bus.alu_b   = acc_lo_q;
            end
            S_FIX_HI1: begin
                bus.alu_sel = 1'b1;
                bus.alu_op  = OP_NOR;
                bus.alu_a   = acc_hi_q;
                bus.alu_b   = acc_hi_q;
            end
            S_FIX_HI2: begin
                bus.alu_sel = 1'b1;
                bus.alu_op  = OP_ADD;
                bus.alu_a   = acc_hi_q;
                bus.alu_b   = {31'b0, (acc_lo_q == '0)};
            end
            default: ;
        endcase
    end

    assign bus.alu_unsig = bus.alu_sel;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;

    // An unsigned add wrapped around exactly when the sum is below an addend.
    assign carry = (bus.alu_out < acc_hi_q);

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        neg_res_d = neg_res_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mcand_d   = bus.rs_val;
                    acc_lo_d  = bus.rt_val;
                    acc_hi_d  = '0;
                    cnt_d     = '0;
                    neg_res_d = bus.signed_op & (bus.rs_val[31] ^ bus.rt_val[31]);
                    if (bus.signed_op && bus.rs_val[31]) begin
                        state_d = S_NEG_A;
                    end else if (bus.signed_op && bus.rt_val[31]) begin
                        state_d = S_NEG_B;
                    end else begin
                        state_d = S_ITER;
                    end
                end
            end
            S_NEG_A: begin
                mcand_d = bus.alu_out;
                // NEG_A implies a signed op, so acc_lo's untouched sign bit is rt's sign.
                state_d = acc_lo_q[31] ? S_NEG_B : S_ITER;
            end
            S_NEG_B: begin
                acc_lo_d = bus.alu_out;
                state_d  = S_ITER;
            end
            S_ITER: begin
                {acc_hi_d, acc_lo_d} = {carry, bus.alu_out, acc_lo_q[31:1]};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = neg_res_q ? S_FIX_LO : S_DONE;
                end
            end
            S_FIX_LO: begin
                acc_lo_d = bus.alu_out;
                state_d  = S_FIX_HI1;
            end
            S_FIX_HI1: begin
                acc_hi_d = bus.alu_out;
                state_d  = S_FIX_HI2;
            end
            S_FIX_HI2: begin
                acc_hi_d = bus.alu_out;
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (bus.cancel && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end

        // The architectural result is committed only on a real arrival at DONE.
        if ((state_d == S_DONE) && (state_q != S_DONE)) begin
            hi_d = acc_hi_d;
            lo_d = acc_lo_d;
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: synchronous reset sampled on the clock edge; there are no memories,
        // so every register including hi/lo is cleared here.
        if (!reset_n) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            neg_res_q <= 1'b0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            neg_res_q <= neg_res_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

endmodule

// File: tb/tb_alu_mult_ctrl.sv
// Directed bench for alu_mult_ctrl: the bench plays the shared Alu and the EX stage,
// checking products, DONE latency, busy windows, cancel and mid-operation reset.
module tb_alu_mult_ctrl;

    logic clock = 1'b0;
    logic reset_n = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    alu_mult_ctrl_if bus ();

    alu_mult_ctrl dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    // Stand-in for the shared Alu.
    always_comb begin
        case (bus.alu_op)
            3'b000:  bus.alu_out = bus.alu_a & bus.alu_b;
            3'b001:  bus.alu_out = bus.alu_a | bus.alu_b;
            3'b010:  bus.alu_out = bus.alu_a + bus.alu_b;
            3'b100:  bus.alu_out = ~(bus.alu_a | bus.alu_b);
            3'b101:  bus.alu_out = bus.alu_a ^ bus.alu_b;
            3'b110:  bus.alu_out = bus.alu_a - bus.alu_b;
            default: bus.alu_out = '0;
        endcase
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    // Issues one operation and observes it cycle by cycle. Cycle k is the k-th cycle
    // after the edge that samples start. Optional start pulse while busy and cancel.
    task automatic do_op(input logic [31:0] rs, input logic [31:0] rt, input logic sgn,
                         input bit chain, input int pulse_at, input int cancel_at,
                         output int done_cyc, output int done_cnt, output bit busy_ok,
                         output logic [31:0] hi_v, output logic [31:0] lo_v,
                         output logic [2:0] op1, output logic [2:0] op2,
                         output bit idle_after);
        int stop_at;
        if (!chain) @(negedge clock);
        bus.rs_val    = rs;
        bus.rt_val    = rt;
        bus.signed_op = sgn;
        bus.start     = 1'b1;
        @(posedge clock);
        done_cyc   = -1;
        done_cnt   = 0;
        busy_ok    = 1'b1;
        hi_v       = '0;
        lo_v       = '0;
        op1        = 3'b111;
        op2        = 3'b111;
        idle_after = 1'b0;
        stop_at    = -1;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clock);
            if (k == 1) bus.start = 1'b0;
            if (k == 1 && bus.alu_sel) op1 = bus.alu_op;
            if (k == 2 && bus.alu_sel) op2 = bus.alu_op;
            if (bus.done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = k;
                    hi_v = bus.hi;
                    lo_v = bus.lo;
                end
            end
            if (k == stop_at) begin
                idle_after = !bus.busy && !bus.done;
                bus.cancel = 1'b0;
                break;
            end
            if (stop_at < 0) busy_ok &= bus.busy;
            if (bus.done && stop_at < 0) stop_at = k + 1;
            if (k == pulse_at) begin
                bus.start     = 1'b1;
                bus.rs_val    = '1;
                bus.rt_val    = '1;
                bus.signed_op = 1'b1;
            end else if (pulse_at > 0 && k == pulse_at + 1) begin
                bus.start = 1'b0;
            end
            if (k == cancel_at) begin
                bus.cancel = 1'b1;
                stop_at    = k + 1;
            end
        end
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.signed_op = 1'b0; bus.cancel = 1'b0;
        bus.rs_val = '0;  bus.rt_val = '0;
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_checks++;
        if ({bus.busy, bus.done, bus.alu_sel} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got busy/done/sel=%b expected 000", {bus.busy, bus.done, bus.alu_sel});
        end
        n_checks++;
        if ({bus.hi, bus.lo} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_hilo: got %h_%h expected 0_0", bus.hi, bus.lo);
        end
        n_checks++;
        if ({bus.alu_a, bus.alu_b, bus.alu_op} !== 67'h0) begin
            n_fail++;
            $display("FAIL reset_alu_drive: got a=%h b=%h op=%b expected 0", bus.alu_a, bus.alu_b, bus.alu_op);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_multu_basic();
        int dc, cnt; bit bok, idl; logic [31:0] h, l; logic [2:0] o1, o2;
        do_op(32'd3, 32'd5, 1'b0, 1'b0, 0, 0, dc, cnt, bok, h, l, o1, o2, idl);
        n_checks++;
        if (dc !== 33) begin n_fail++; $display("FAIL multu_3x5 done_cycle: got %0d expected 33", dc); end
        n_checks++;
        if (cnt !== 1 || idl !== 1'b1) begin
            n_fail++; $display("FAIL multu_3x5 done_pulse: got count=%0d idle_after=%0d expected 1/1", cnt, idl);
        end
        n_checks++;
        if (bok !== 1'b1) begin n_fail++; $display("FAIL multu_3x5 busy_window: got %0d expected 1", bok); end
        n_checks++;
        if (h !== 32'h0 || l !== 32'hF) begin
            n_fail++; $display("FAIL multu_3x5 result: got %h_%h expected 00000000_0000000f", h, l);
        end
        n_checks++;
        if (o1 !== 3'b010) begin n_fail++; $display("FAIL multu_3x5 first_op: got %b expected 010", o1); end
    endtask

    task automatic test_multu_max();
        int dc, cnt; bit bok, idl; logic [31:0] h, l; logic [2:0] o1, o2;
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, 0, dc, cnt, bok, h, l, o1, o2, idl);
        n_checks++;
        if (dc !== 33) begin n_fail++; $display("FAIL multu_max done_cycle: got %0d expected 33", dc); end
        n_checks++;
        if (h !== 32'hFFFF_FFFE || l !== 32'h1) begin
            n_fail++; $display("FAIL multu_max result: got %h_%h expected fffffffe_00000001", h, l);
        end
    endtask

    task automatic test_mult_neg();
        int dc, cnt; bit bok, idl; logic [31:0] h, l; logic [2:0] o1, o2;
        do_op(32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0, 0, 0, dc, cnt, bok, h, l, o1, o2, idl);
        n_checks++;
        if (dc !== 37) begin n_fail++; $display("FAIL mult_m3x5 done_cycle: got %0d expected 37", dc); end
        n_checks++;
        if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFF1) begin
            n_fail++; $display("FAIL mult_m3x5 result: got %h_%h expected ffffffff_fffffff1", h, l);
        end
        n_checks++;
        if (o1 !== 3'b110 || o2 !== 3'b010) begin
            n_fail++; $display("FAIL mult_m3x5 ops: got %b,%b expected 110,010", o1, o2);
        end
        n_checks++;
        if (bok !== 1'b1 || idl !== 1'b1) begin
            n_fail++; $display("FAIL mult_m3x5 busy_window: got busy_ok=%0d idle_after=%0d expected 1/1", bok, idl);
        end
        do_op(32'hFFFF_FFF9, 32'd0, 1'b1, 1'b0, 0, 0, dc, cnt, bok, h, l, o1, o2, idl);
        n_checks++;
        if (dc !== 37) begin n_fail++; $display("FAIL mult_m7x0 done_cycle: got %0d expected 37", dc); end
        n_checks++;
        if (h !== 32'h0 || l !== 32'h0) begin
            n_fail++; $display("FAIL mult_m7x0 result: got %h_%h expected 00000000_00000000", h, l);
        end
    endtask

    task automatic test_mult_min();
        int dc, cnt; bit bok, idl; logic [31:0] h, l; logic [2:0] o1, o2;
        do_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 0, 0, dc, cnt, bok, h, l, o1, o2, idl);
        n_checks++;
        if (dc !== 35) begin n_fail++; $display("FAIL mult_min done_cycle: got %0d expected 35", dc); end
        n_checks++;
        if (h !== 32'h4000_0000 || l !== 32'h0) begin
            n_fail++; $display("FAIL mult_min result: got %h_%h expected 40000000_00000000", h, l);
        end
        n_checks++;
        if (o1 !== 3'b110 || o2 !== 3'b110) begin
            n_fail++; $display("FAIL mult_min neg_ops: got %b,%b expected 110,110", o1, o2);
        end
    endtask

    task automatic test_cancel();
        int dc, cnt; bit bok, idl; logic [31:0] h, l; logic [2:0] o1, o2;
        do_op(32'd3, 32'd5, 1'b0, 1'b0, 0, 0, dc, cnt, bok, h, l, o1, o2, idl);
        n_checks++;
        if (l !== 32'd15) begin n_fail++; $display("FAIL cancel_setup result: got lo=%h expected 0000000f", l); end
        do_op(32'd7, 32'd9, 1'b0, 1'b0, 3, 10, dc, cnt, bok, h, l, o1, o2, idl);
        n_checks++;
        if (cnt !== 0) begin n_fail++; $display("FAIL cancel no_done: got done count %0d expected 0", cnt); end
        n_checks++;
        if (idl !== 1'b1 || bok !== 1'b1) begin
            n_fail++; $display("FAIL cancel idle_next: got idle=%0d busy_ok=%0d expected 1/1", idl, bok);
        end
        n_checks++;
        if (bus.hi !== 32'h0 || bus.lo !== 32'd15) begin
            n_fail++; $display("FAIL cancel hilo_kept: got %h_%h expected 00000000_0000000f", bus.hi, bus.lo);
        end
        do_op(32'd7, 32'd9, 1'b0, 1'b1, 5, 0, dc, cnt, bok, h, l, o1, o2, idl);
        n_checks++;
        if (dc !== 33) begin n_fail++; $display("FAIL restart done_cycle: got %0d expected 33", dc); end
        n_checks++;
        if (h !== 32'h0 || l !== 32'd63) begin
            n_fail++; $display("FAIL restart result: got %h_%h expected 00000000_0000003f", h, l);
        end
    endtask

    task automatic test_back_to_back();
        int dc, cnt; bit bok, idl; logic [31:0] h, l; logic [2:0] o1, o2;
        do_op(32'd2, 32'd3, 1'b0, 1'b0, 0, 0, dc, cnt, bok, h, l, o1, o2, idl);
        n_checks++;
        if (dc !== 33 || l !== 32'd6) begin
            n_fail++; $display("FAIL b2b_first: got cycle=%0d lo=%h expected 33/00000006", dc, l);
        end
        do_op(32'd4, 32'd5, 1'b0, 1'b1, 0, 0, dc, cnt, bok, h, l, o1, o2, idl);
        n_checks++;
        if (dc !== 33 || l !== 32'd20 || h !== 32'h0) begin
            n_fail++; $display("FAIL b2b_second: got cycle=%0d hi=%h lo=%h expected 33/00000000/00000014", dc, h, l);
        end
    endtask

    task automatic test_reset_mid();
        int dc, cnt; bit bok, idl; logic [31:0] h, l; logic [2:0] o1, o2;
        @(negedge clock);
        bus.rs_val = 32'd9; bus.rt_val = 32'd9; bus.signed_op = 1'b0; bus.start = 1'b1;
        @(posedge clock);
        repeat (15) @(negedge clock);
        bus.start = 1'b0;
        reset_n   = 1'b0;
        bus.start = 1'b1;
        bus.cancel = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset_n    = 1'b1;
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        n_checks++;
        if ({bus.busy, bus.done, bus.alu_sel} !== 3'b000) begin
            n_fail++; $display("FAIL reset_mid flags: got busy/done/sel=%b expected 000", {bus.busy, bus.done, bus.alu_sel});
        end
        n_checks++;
        if ({bus.hi, bus.lo} !== 64'h0 || {bus.alu_a, bus.alu_b, bus.alu_op} !== 67'h0) begin
            n_fail++; $display("FAIL reset_mid outputs: got hi=%h lo=%h a=%h b=%h op=%b expected all 0",
                               bus.hi, bus.lo, bus.alu_a, bus.alu_b, bus.alu_op);
        end
        do_op(32'd2, 32'd2, 1'b0, 1'b1, 0, 0, dc, cnt, bok, h, l, o1, o2, idl);
        n_checks++;
        if (dc !== 33 || l !== 32'd4) begin
            n_fail++; $display("FAIL reset_mid restart: got cycle=%0d lo=%h expected 33/00000004", dc, l);
        end
    endtask

    initial begin
        test_reset();
        test_multu_basic();
        test_multu_max();
        test_mult_neg();
        test_mult_min();
        test_cancel();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
